// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and oversampled bit timing.
// A single-entry holding register keeps the received byte, with sticky frame and overrun flags.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       sample_edge,
  output logic [7:0] data,
  output logic       valid,
  input  logic       read,
  input  logic       err_clr,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ovr_q, ovr_d;
  logic          rx_meta_q, rx_sync_q;
  logic          deliver, frame_set, ovr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  // Frame FSM: everything except the holding register advances only on sample_edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    frame_set = 1'b0;
    if (sample_edge) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            shift_d = {rx_sync_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (rx_sync_q) begin
              deliver = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_BREAK: begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Holding register and sticky flags; a read in the delivery cycle makes room for the new byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    ovr_set = 1'b0;
    if (deliver) begin
      if (!valid_q || read) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (read) begin
      valid_d = 1'b0;
    end
    if (err_clr) begin
      fe_d  = 1'b0;
      ovr_d = 1'b0;
    end
    if (frame_set) begin
      fe_d = 1'b1;
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule
